// File: rtl/key_debounce_if.sv
// key_debounce_if: bundles the raw key level and the debounced key outputs.
// master = key source / consumer side, slave = the debouncer itself.
interface key_debounce_if;
  logic key_in;       // raw level, 0 = pressed, may bounce, asynchronous
  logic key_state;    // debounced level, 1 = pressed
  logic key_press;    // one-cycle pulse on accepted press
  logic key_release;  // one-cycle pulse on accepted release
  logic key_long;     // one-cycle pulse on long press

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: push-button debouncer.
// Raw active-low key -> 2-FF synchroniser -> 4-state filter FSM that accepts a
// level change only after DEBOUNCE_CYCLES stable cycles. Produces a clean
// level plus single-cycle press/release pulses.
// Optional feature macro: LONG_PRESS_EN. When defined, a hold counter fires a
// single key_long pulse after LONG_CYCLES cycles held down; otherwise key_long = 0.
// DEBOUNCE_CYCLES must be >= 2.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_FILT_DN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_FILT_UP = 2'd3;

  logic             sync1_reg;
  logic             key_sync_reg;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             key_state_reg, key_state_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  // Two-flop synchroniser; idles at 1 (released) so reset exit never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b1;
      key_sync_reg <= 1'b1;
    end else begin
      sync1_reg    <= bus.key_in;
      key_sync_reg <= sync1_reg;
    end
  end

  // Filter FSM: any disagreeing sample during a filter window abandons it
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    key_state_next = key_state_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    case (state_reg)
      ST_UP: begin
        if (!key_sync_reg) begin
          state_next = ST_FILT_DN;
          cnt_next   = '0;
        end
      end
      ST_FILT_DN: begin
        if (key_sync_reg) begin
          state_next = ST_UP;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next     = ST_DOWN;
          cnt_next       = '0;
          key_state_next = 1'b1;
          press_next     = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (key_sync_reg) begin
          state_next = ST_FILT_UP;
          cnt_next   = '0;
        end
      end
      ST_FILT_UP: begin
        if (!key_sync_reg) begin
          state_next = ST_DOWN;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next     = ST_UP;
          cnt_next       = '0;
          key_state_next = 1'b0;
          release_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next     = ST_UP;
        cnt_next       = '0;
        key_state_next = 1'b0;
      end
    endcase
  end

  // FSM state, filter counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_UP;
      cnt_reg       <= '0;
      key_state_reg <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_state_reg <= key_state_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
    end
  end

  assign bus.key_state   = key_state_reg;
  assign bus.key_press   = press_reg;
  assign bus.key_release = release_reg;

`ifdef LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              long_reg, long_next;

  // Hold counter: restarts only on an accepted press, so a release glitch
  // (FILT_UP back to DOWN) cannot produce a second key_long for the same press.
  // Saturating one past the fire value guarantees a single pulse.
  always_comb begin
    hold_next = hold_reg;
    long_next = 1'b0;
    if (state_reg == ST_FILT_DN && state_next == ST_DOWN) begin
      hold_next = '0;
    end else if (state_reg == ST_DOWN || state_reg == ST_FILT_UP) begin
      if (hold_reg != HOLD_MAX) begin
        hold_next = hold_reg + HOLD_ONE;
      end
      if (hold_reg == HOLD_FIRE && key_state_next) begin
        long_next = 1'b1;
      end
    end else begin
      hold_next = '0;
    end
  end

  // Hold counter and long-press pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      long_reg <= long_next;
    end
  end

  assign bus.key_long = long_reg;
`else
  assign bus.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: self-checking bench for key_debounce (D=100, L=1000, 20 ns clock).
// A reference model checks every cycle; directed vectors and sequences also
// check latencies and pulse counts. Honours LONG_PRESS_EN.
module tb_key_debounce;
  localparam int D = 100;
  localparam int L = 1000;
  localparam int LAT = D + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  key_debounce_if kif ();

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: accepted level = level seen for D+1 consecutive edges,
  // where "seen" is key_in delayed by two edges
  bit hist[$];
  bit run_val;
  int run_len;
  bit m_state, m_press, m_release, m_long;
  int since_press;

  // observation bookkeeping
  int n_press, n_release, n_long;
  int last_press_cyc, last_release_cyc, last_long_cyc;
  logic prev_press = 1'b0, prev_release = 1'b0, prev_long = 1'b0;

  typedef struct {
    int low_cycles;
    int exp_presses;
    int exp_releases;
    int exp_press_lat;
    int exp_rel_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit seen;
    if (rst) begin
      hist = {1'b1, 1'b1};
      run_val = 1'b1;
      run_len = 0;
      m_state = 1'b0;
      m_press = 1'b0;
      m_release = 1'b0;
      m_long = 1'b0;
      since_press = 0;
    end else begin
      seen = hist[0];
      void'(hist.pop_front());
      hist.push_back(kif.key_in);
      if (seen == run_val) run_len++;
      else begin
        run_val = seen;
        run_len = 1;
      end
      m_press = 1'b0;
      m_release = 1'b0;
      m_long = 1'b0;
      if (run_len == D + 1 && (seen == 1'b0) != m_state) begin
        m_state = (seen == 1'b0);
        if (m_state) m_press = 1'b1;
        else m_release = 1'b1;
      end
      if (m_press) since_press = 0;
      else if (m_state && since_press <= L) since_press++;
      if (!m_state) since_press = 0;
`ifdef LONG_PRESS_EN
      m_long = m_state && !m_press && (since_press == L);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #2;
    check("key_state", kif.key_state, m_state);
    check("key_press", kif.key_press, m_press);
    check("key_release", kif.key_release, m_release);
    check("key_long", kif.key_long, m_long);
    check("press_and_release", kif.key_press & kif.key_release, 0);
    if (prev_press) check("press_width", kif.key_press, 0);
    if (prev_release) check("release_width", kif.key_release, 0);
    if (prev_long) check("long_width", kif.key_long, 0);
    if (kif.key_press) begin n_press++; last_press_cyc = cyc; end
    if (kif.key_release) begin n_release++; last_release_cyc = cyc; end
    if (kif.key_long) begin n_long++; last_long_cyc = cyc; end
    prev_press = kif.key_press;
    prev_release = kif.key_release;
    prev_long = kif.key_long;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_long = 0;
    last_press_cyc = -1; last_release_cyc = -1; last_long_cyc = -1;
  endtask

  initial begin
    int edge_cyc, rel_cyc, gap, len;

    // low-pulse length -> expected pulses and latencies
    vecs[0] = '{5,   0, 0, 0,   0};
    vecs[1] = '{99,  0, 0, 0,   0};
    vecs[2] = '{100, 0, 0, 0,   0};
    vecs[3] = '{101, 1, 1, LAT, LAT};
    vecs[4] = '{102, 1, 1, LAT, LAT};
    vecs[5] = '{500, 1, 1, LAT, LAT};

    kif.key_in = 1'b1;
    rst = 1'b1;
    clear_counts();
    run(3);
    check("reset_key_state", kif.key_state, 0);
    check("reset_key_press", kif.key_press, 0);
    rst = 1'b0;
    run(10);

    // table-driven press/release vectors
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      edge_cyc = cyc;
      kif.key_in = 1'b0;
      run(vecs[i].low_cycles);
      rel_cyc = cyc;
      kif.key_in = 1'b1;
      run(250);
      check("vec_presses", n_press, vecs[i].exp_presses);
      check("vec_releases", n_release, vecs[i].exp_releases);
      if (vecs[i].exp_presses > 0) begin
        check("vec_press_lat", last_press_cyc - edge_cyc, vecs[i].exp_press_lat);
        check("vec_rel_lat", last_release_cyc - rel_cyc, vecs[i].exp_rel_lat);
      end
      check("vec_final_state", kif.key_state, 0);
      $display("vector %0d: low=%0d presses=%0d releases=%0d", i, vecs[i].low_cycles, n_press, n_release);
    end

    // bounce on press, then bounce on release
    clear_counts();
    for (int t = 0; t < 50; t++) begin
      kif.key_in = ~kif.key_in;
      gap = $urandom_range(1, 90);
      run(gap);
    end
    kif.key_in = 1'b0;
    edge_cyc = cyc;
    run(300);
    check("bounce_presses", n_press, 1);
    check("bounce_press_lat", last_press_cyc - edge_cyc, LAT);
    for (int t = 0; t < 50; t++) begin
      kif.key_in = ~kif.key_in;
      gap = $urandom_range(1, 90);
      run(gap);
    end
    kif.key_in = 1'b1;
    edge_cyc = cyc;
    run(300);
    check("bounce_releases", n_release, 1);
    check("bounce_rel_lat", last_release_cyc - edge_cyc, LAT);
    $display("bounce: presses=%0d releases=%0d", n_press, n_release);

    // reset in the middle of the press filter with key held low
    kif.key_in = 1'b0;
    run(3 + 50);
    rst = 1'b1;
    run(4);
    check("rst_key_state", kif.key_state, 0);
    check("rst_key_press", kif.key_press, 0);
    clear_counts();
    rst = 1'b0;
    edge_cyc = cyc;
    run(200);
    check("rst_presses", n_press, 1);
    check("rst_press_lat", last_press_cyc - edge_cyc, LAT);
    kif.key_in = 1'b1;
    run(250);
    $display("reset mid-filter: presses=%0d", n_press);

    // long press
    clear_counts();
    kif.key_in = 1'b0;
    run(3000);
    check("long_presses", n_press, 1);
`ifdef LONG_PRESS_EN
    check("long_count", n_long, 1);
    check("long_lat", last_long_cyc - last_press_cyc, L);
`else
    check("long_count", n_long, 0);
`endif
    kif.key_in = 1'b1;
    run(300);
    $display("long press: presses=%0d longs=%0d", n_press, n_long);

    // randomized segments with occasional resets, checked by the model each cycle
    clear_counts();
    for (int s = 0; s < 150; s++) begin
      kif.key_in = ~kif.key_in;
      if ($urandom_range(0, 9) == 0) len = $urandom_range(900, 1300);
      else len = $urandom_range(1, 130);
      if ($urandom_range(0, 19) == 0) begin
        run(len / 2);
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
        run(len - len / 2);
      end else begin
        run(len);
      end
    end
    kif.key_in = 1'b1;
    run(300);
    $display("random: presses=%0d releases=%0d longs=%0d", n_press, n_release, n_long);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
